// File: rtl/irq_ctrl.sv
// Platform interrupt controller: latches edge/level sources, arbitrates by priority
// against a threshold, and presents one registered request plus mcause to the trap unit.
module irq_ctrl #(
  parameter int NUM_IRQ  = 16,
  parameter int IRQ_BASE = 16,
  parameter int PRIO_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               reg_rd_en,
  input  logic               reg_wr_en,
  input  logic [3:0]         reg_addr,
  input  logic [31:0]        reg_wr_data,
  output logic [31:0]        reg_rd_data,
  output logic               irq_req,
  output logic [31:0]        irq_cause,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               in_service,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SVC = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d, enable_q, edge_q, irq_prev_q;
  logic [PRIO_W-1:0]   thresh_q;
  logic [PRIO_W-1:0]   prio_q [NUM_IRQ];
  logic [4:0]          idx_q, idx_d;
  logic [31:0]         cause_q, cause_d;

  logic [NUM_IRQ-1:0]  eligible, ack_clr, w1c, edge_chg, edge_set;
  logic                any_elig, cur_elig;
  logic [4:0]          win_idx;
  logic [PRIO_W-1:0]   win_prio;
  logic                wr_pend, wr_enable, wr_edge, wr_thresh;
  logic                unused_wr_bits;

  assign wr_pend   = reg_wr_en && (reg_addr == 4'd0);
  assign wr_enable = reg_wr_en && (reg_addr == 4'd1);
  assign wr_edge   = reg_wr_en && (reg_addr == 4'd2);
  assign wr_thresh = reg_wr_en && (reg_addr == 4'd3);
  assign unused_wr_bits = ^reg_wr_data;

  // Ascending scan with strict '>' keeps the lowest index on priority ties.
  always_comb begin
    eligible = '0;
    any_elig = 1'b0;
    win_idx  = '0;
    win_prio = '0;
    cur_elig = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      eligible[i] = pending_q[i] && enable_q[i] && (prio_q[i] > thresh_q);
      if (eligible[i] && (!any_elig || (prio_q[i] > win_prio))) begin
        any_elig = 1'b1;
        win_idx  = 5'(i);
        win_prio = prio_q[i];
      end
      if (idx_q == 5'(i)) cur_elig = eligible[i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cause_d = cause_q;
    ack_clr = '0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = REQ;
          idx_d   = win_idx;
          cause_d = {1'b1, 31'(IRQ_BASE) + 31'(win_idx)};
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d = SVC;
          for (int i = 0; i < NUM_IRQ; i++)
            if (idx_q == 5'(i)) ack_clr[i] = edge_q[i];
        end else if (!cur_elig) begin
          state_d = IDLE;
        end
      end
      SVC: begin
        if (irq_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge wins over W1C/ack clears; a mode change wipes the bit outright.
  assign w1c       = wr_pend ? (reg_wr_data[NUM_IRQ-1:0] & edge_q) : '0;
  assign edge_chg  = wr_edge ? (reg_wr_data[NUM_IRQ-1:0] ^ edge_q) : '0;
  assign edge_set  = irq_in & ~irq_prev_q;
  assign pending_d = ~edge_chg &
                     ((edge_q & (edge_set | (pending_q & ~w1c & ~ack_clr))) |
                      (~edge_q & irq_in));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cause_q    <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      edge_q     <= '0;
      irq_prev_q <= '0;
      thresh_q   <= '0;
      for (int i = 0; i < NUM_IRQ; i++) prio_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cause_q    <= cause_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_in;
      if (wr_enable) enable_q <= reg_wr_data[NUM_IRQ-1:0];
      if (wr_edge)   edge_q   <= reg_wr_data[NUM_IRQ-1:0];
      if (wr_thresh) thresh_q <= reg_wr_data[PRIO_W-1:0];
      for (int i = 0; i < NUM_IRQ; i++)
        if (reg_wr_en && (reg_addr == 4'(4 + i / 8)))
          prio_q[i] <= reg_wr_data[4*(i%8) +: PRIO_W];
    end
  end

  assign irq_req    = (state_q == REQ);
  assign in_service = (state_q == SVC);
  assign irq_cause  = cause_q;
  assign state_dbg  = state_q;

  always_comb begin
    reg_rd_data = '0;
    if (reg_rd_en) begin
      case (reg_addr)
        4'd0:    reg_rd_data = 32'(pending_q);
        4'd1:    reg_rd_data = 32'(enable_q);
        4'd2:    reg_rd_data = 32'(edge_q);
        4'd3:    reg_rd_data = 32'(thresh_q);
        4'd8:    reg_rd_data = {in_service, 26'b0, idx_q};
        default: reg_rd_data = '0;
      endcase
      for (int i = 0; i < NUM_IRQ; i++)
        if (reg_addr == 4'(4 + i / 8))
          reg_rd_data[4*(i%8) +: PRIO_W] = prio_q[i];
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run against
// a cycle-level reference model kept in plain arrays.
module tb_irq_ctrl;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          reg_rd_en, reg_wr_en;
  logic [3:0]    reg_addr;
  logic [31:0]   reg_wr_data, reg_rd_data;
  logic          irq_req, irq_ack, irq_done, in_service;
  logic [31:0]   irq_cause;
  logic [1:0]    state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pend, m_en, m_edge, m_prev, m_cause;
  int          m_prio [N];
  int          m_thr, m_mode, m_idx;   // m_mode: 0 waiting, 1 requesting, 2 servicing
  logic [31:0] exp_q [$];              // causes granted and not yet taken or withdrawn

  irq_ctrl #(.NUM_IRQ(N), .IRQ_BASE(16), .PRIO_W(3)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in),
    .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
    .irq_req(irq_req), .irq_cause(irq_cause), .irq_ack(irq_ack),
    .irq_done(irq_done), .in_service(in_service), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_elig(input int i);
    return m_pend[i] && m_en[i] && (m_prio[i] > m_thr);
  endfunction

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r = '0;
    case (a)
      0: r = m_pend;
      1: r = m_en;
      2: r = m_edge;
      3: r = 32'(m_thr);
      4, 5, 6, 7: for (int i = 0; i < N; i++)
        if (i / 8 == a - 4) r = r | (32'(m_prio[i]) << (4 * (i % 8)));
      8: r = {(m_mode == 2), 26'b0, 5'(m_idx)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    int best, bscore, sc, nm, nidx, ackc;
    logic [31:0] np, ncause, e;
    if (rst) begin
      m_pend = '0; m_en = '0; m_edge = '0; m_prev = '0; m_cause = '0;
      m_thr = 0; m_mode = 0; m_idx = 0;
      for (int i = 0; i < N; i++) m_prio[i] = 0;
      exp_q.delete();
    end else begin
      best = -1; bscore = -1;
      for (int i = 0; i < N; i++) begin
        sc = m_prio[i] * 64 + (63 - i);
        if (m_elig(i) && sc > bscore) begin bscore = sc; best = i; end
      end
      nm = m_mode; nidx = m_idx; ncause = m_cause; ackc = -1;
      if (m_mode == 0) begin
        if (best >= 0) begin
          nm = 1; nidx = best;
          ncause = 32'h8000_0000 | 32'(16 + best);
          exp_q.push_back(ncause);
        end
      end else if (m_mode == 1) begin
        if (irq_ack) begin
          nm = 2;
          if (m_edge[m_idx]) ackc = m_idx;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ack_cause", irq_cause, e);
          end
        end else if (!m_elig(m_idx)) begin
          nm = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else if (irq_done) begin
        nm = 0;
      end
      np = m_pend;
      for (int i = 0; i < N; i++) begin
        if (reg_wr_en && reg_addr == 4'd2 && reg_wr_data[i] != m_edge[i]) np[i] = 1'b0;
        else if (m_edge[i]) begin
          if (irq_in[i] && !m_prev[i]) np[i] = 1'b1;
          else if ((reg_wr_en && reg_addr == 4'd0 && reg_wr_data[i]) || i == ackc) np[i] = 1'b0;
        end else np[i] = irq_in[i];
      end
      if (reg_wr_en) begin
        case (reg_addr)
          4'd1: m_en   = reg_wr_data & 32'h0000_FFFF;
          4'd2: m_edge = reg_wr_data & 32'h0000_FFFF;
          4'd3: m_thr  = int'(reg_wr_data & 32'd7);
          4'd4, 4'd5, 4'd6, 4'd7: for (int i = 0; i < N; i++)
            if (i / 8 == int'(reg_addr) - 4) m_prio[i] = int'((reg_wr_data >> (4 * (i % 8))) & 32'd7);
          default: ;
        endcase
      end
      m_pend = np; m_mode = nm; m_idx = nidx; m_cause = ncause;
      m_prev = 32'(irq_in);
    end
  endtask

  // Driver tasks: called at the falling edge, outputs checked at the next falling edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("req_vs_model", 32'(irq_req), 32'(m_mode == 1));
    chk("svc_vs_model", 32'(in_service), 32'(m_mode == 2));
    if (m_mode == 1) chk("cause_vs_model", irq_cause, m_cause);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_wr_en = 1'b1; reg_addr = a; reg_wr_data = d;
    cyc();
    reg_wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    reg_rd_en = 1'b1; reg_addr = a;
    #1;
    chk(tag, reg_rd_data, exp);
    reg_rd_en = 1'b0;
  endtask

  task automatic wait_req(input int max_cyc);
    int k;
    k = 0;
    while (!irq_req && k < max_cyc) begin cyc(); k++; end
    chk("wait_req", 32'(irq_req), 32'd1);
  endtask

  task automatic pulse(input logic [N-1:0] bits);
    irq_in = irq_in | bits;
    cyc();
    irq_in = irq_in & ~bits;
  endtask

  task automatic ack_cyc();
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
  endtask

  task automatic done_cyc();
    irq_done = 1'b1; cyc(); irq_done = 1'b0;
  endtask

  task automatic rand_config();
    wr(4'd2, $urandom);
    wr(4'd1, 32'h0000_FFFF);
    wr(4'd4, $urandom & 32'h7777_7777);
    wr(4'd5, $urandom & 32'h7777_7777);
    wr(4'd3, 32'($urandom_range(0, 2)));
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; reg_rd_en = 1'b0; reg_wr_en = 1'b0;
    reg_addr = '0; reg_wr_data = '0; irq_ack = 1'b0; irq_done = 1'b0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_cause", irq_cause, 32'd0);
    chk("rst_svc", 32'(in_service), 32'd0);
    chk("rst_rd", reg_rd_data, 32'd0);
    rst = 1'b0;

    // Reset contents and masked sources
    for (int a = 0; a < 10; a++) rd_chk("rst_reg", 4'(a), 32'd0);
    irq_in = '1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("disabled_no_req", 32'(irq_req), 32'd0);
    end
    rd_chk("level_pending", 4'd0, 32'h0000_FFFF);
    irq_in = '0;
    cyc(); cyc();

    // Single edge source: latency and ack
    wr(4'd2, 32'h1); wr(4'd1, 32'h1); wr(4'd4, 32'h2); wr(4'd3, 32'h0);
    irq_in[0] = 1'b1;
    cyc();
    chk("edge_n1_req", 32'(irq_req), 32'd0);
    rd_chk("edge_n1_pend", 4'd0, 32'h1);
    irq_in[0] = 1'b0;
    cyc();
    chk("edge_n2_req", 32'(irq_req), 32'd1);
    chk("edge_cause", irq_cause, 32'h8000_0010);
    ack_cyc();
    chk("ack_svc", 32'(in_service), 32'd1);
    chk("ack_req_low", 32'(irq_req), 32'd0);
    rd_chk("ack_pend_clr", 4'd0, 32'h0);
    rd_chk("claim_svc", 4'd8, 32'h8000_0000);
    reg_rd_en = 1'b0; reg_addr = 4'd1; #1;
    chk("rd_gated", reg_rd_data, 32'd0);
    done_cyc();
    chk("done_idle", 32'(in_service), 32'd0);

    // Priority and tie-break
    wr(4'd2, 32'h8B); wr(4'd1, 32'h8B); wr(4'd4, 32'h6000_5052);
    pulse(16'h008A);
    wait_req(4);
    chk("prio_top", irq_cause, 32'h8000_0017);
    ack_cyc(); done_cyc();
    wait_req(4);
    chk("prio_tie", irq_cause, 32'h8000_0011);
    ack_cyc(); done_cyc();
    wait_req(4);
    chk("prio_last", irq_cause, 32'h8000_0013);
    ack_cyc(); done_cyc();

    // Threshold and level withdrawal
    wr(4'd1, 32'h8F); wr(4'd4, 32'h6000_5352); wr(4'd3, 32'd3);
    irq_in[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("thresh_block", 32'(irq_req), 32'd0);
    end
    wr(4'd3, 32'd2);
    wait_req(4);
    chk("thresh_pass", irq_cause, 32'h8000_0012);
    irq_in[2] = 1'b0;
    cyc(); cyc();
    chk("withdraw_req", 32'(irq_req), 32'd0);
    chk("withdraw_svc", 32'(in_service), 32'd0);
    wr(4'd3, 32'd0);

    // Collisions: edge vs W1C, edge vs ack
    wr(4'd2, 32'h9B); wr(4'd1, 32'h9F); wr(4'd4, 32'h6004_5352);
    irq_in[4] = 1'b1;
    wr(4'd0, 32'h10);
    rd_chk("edge_beats_w1c", 4'd0, 32'h10);
    irq_in[4] = 1'b0;
    cyc();
    chk("src4_req", 32'(irq_req), 32'd1);
    chk("src4_cause", irq_cause, 32'h8000_0014);
    irq_in[4] = 1'b1;
    ack_cyc();
    irq_in[4] = 1'b0;
    chk("src4_svc", 32'(in_service), 32'd1);
    rd_chk("edge_beats_ack", 4'd0, 32'h10);
    done_cyc();
    wait_req(4);
    chk("src4_rereq", irq_cause, 32'h8000_0014);
    ack_cyc(); done_cyc();

    // No nesting while in service
    wr(4'd2, 32'hBB); wr(4'd1, 32'hBF); wr(4'd4, 32'h6074_5352);
    pulse(16'h0010);
    wait_req(4);
    chk("nest_first", irq_cause, 32'h8000_0014);
    ack_cyc();
    rd_chk("claim_src4", 4'd8, 32'h8000_0004);
    pulse(16'h0020);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("no_nest", 32'(irq_req), 32'd0);
    end
    done_cyc();
    chk("done_gap", 32'(irq_req), 32'd0);
    wait_req(4);
    chk("nest_after", irq_cause, 32'h8000_0015);
    ack_cyc(); done_cyc();

    // Randomized traffic against the model, with one mid-run reset
    rand_config();
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        irq_in = '0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_cause", irq_cause, 32'd0);
        rd_chk("midrst_claim", 4'd8, 32'd0);
        rd_chk("midrst_en", 4'd1, 32'd0);
        rand_config();
      end
      if ($urandom_range(0, 9) == 0) begin
        reg_addr = 4'($urandom_range(0, 9));
        rd_chk("rand_rd", reg_addr, m_read(int'(reg_addr)));
      end
      irq_in   = irq_in ^ 16'($urandom & $urandom & $urandom);
      irq_ack  = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      irq_done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) begin
        reg_wr_en   = 1'b1;
        reg_addr    = 4'($urandom_range(0, 9));
        reg_wr_data = (reg_addr == 4'd3) ? 32'($urandom_range(0, 3)) : $urandom;
      end
      cyc();
      reg_wr_en = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
